// File: rtl/bank_stream_ctrl.sv
// bank_stream_ctrl
// Stream-side controller for a single-port coefficient bank with a
// one-cycle registered read. A load command writes an input stream into
// consecutive bank addresses. A drain command reads consecutive addresses
// and presents them on an output stream. A two-entry skid FIFO absorbs the
// read latency and downstream backpressure.
//
// Handshake semantics (both streams): a word moves on the rising clk edge
// where valid && ready are both high. A producer that raises valid keeps
// valid and its payload stable until that edge. s_ready and m_valid are
// functions of registered state only, so neither has a combinational path
// from the opposite side of its own handshake.
module bank_stream_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 21
) (
   input  logic                  clk,
   input  logic                  rst,
   // command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rd,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH-1:0] cmd_len_m1,
   // load stream
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   // drain stream
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   // bank port
   output logic [ADDR_WIDTH-1:0] bank_addr,
   output logic [DATA_WIDTH-1:0] bank_data_in,
   output logic                  bank_we,
   input  logic [DATA_WIDTH-1:0] bank_data_out,
   // status
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH-1:0]   len_q, len_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   rcnt_q, rcnt_d;
   logic                    all_issued_q, all_issued_d;
   logic                    pend_q, pend_d;
   logic                    pend_last_q, pend_last_d;
   logic                    done_q, done_d;

   // skid FIFO: two entries, one-bit pointers, occupancy 0..2
   logic [DATA_WIDTH-1:0]   fifo_data_q [2];
   logic                    fifo_last_q [2];
   logic [1:0]              occ_q, occ_d;
   logic                    wr_ptr_q, wr_ptr_d;
   logic                    rd_ptr_q, rd_ptr_d;

   logic                    push;
   logic                    pop;
   logic                    issue;
   logic [2:0]              occ_proj;

   // Status and stream outputs straight from registered state.
   assign cmd_ready = (state_q == ST_IDLE);
   assign s_ready   = (state_q == ST_LOAD);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign dbg_state = state_q;
   assign m_valid   = (occ_q != 2'd0);
   assign m_data    = fifo_data_q[rd_ptr_q];
   assign m_last    = fifo_last_q[rd_ptr_q];

   // FIFO bookkeeping: a read issued last cycle lands this cycle; occ_proj
   // is the occupancy the FIFO will have once that word and any pop settle.
   always_comb begin
      push     = pend_q;
      pop      = (occ_q != 2'd0) && m_ready;
      occ_proj = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
      occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
   end

   // Next-state and bank-port logic for IDLE / LOAD / DRAIN.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      rcnt_d       = rcnt_q;
      all_issued_d = all_issued_q;
      pend_d       = 1'b0;
      pend_last_d  = 1'b0;
      done_d       = 1'b0;
      issue        = 1'b0;
      bank_addr    = '0;
      bank_data_in = '0;
      bank_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               base_d       = cmd_base;
               len_d        = cmd_len_m1;
               cnt_d        = '0;
               rcnt_d       = '0;
               all_issued_d = 1'b0;
               state_d      = cmd_rd ? ST_DRAIN : ST_LOAD;
            end
         end

         ST_LOAD: begin
            // s_ready is 1 here, so every s_valid is a handshake.
            bank_addr    = base_q + cnt_q;
            bank_data_in = s_data;
            bank_we      = s_valid;
            if (s_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == len_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         ST_DRAIN: begin
            bank_addr = base_q + rcnt_q;
            // Never let stored plus in-flight words exceed the FIFO depth.
            issue = !all_issued_q && (occ_proj < 3'd2);
            if (issue) begin
               pend_d      = 1'b1;
               pend_last_d = (rcnt_q == len_q);
               rcnt_d      = rcnt_q + 1'b1;
               if (rcnt_q == len_q) begin
                  all_issued_d = 1'b1;
               end
            end
            if (pop && m_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         base_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         rcnt_q       <= '0;
         all_issued_q <= 1'b0;
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         done_q       <= 1'b0;
         occ_q        <= 2'd0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         rcnt_q       <= rcnt_d;
         all_issued_q <= all_issued_d;
         pend_q       <= pend_d;
         pend_last_q  <= pend_last_d;
         done_q       <= done_d;
         occ_q        <= occ_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Skid FIFO storage: capture the bank word the cycle after its read.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_last_q[0] <= 1'b0;
         fifo_last_q[1] <= 1'b0;
      end else if (push) begin
         fifo_data_q[wr_ptr_q] <= bank_data_out;
         fifo_last_q[wr_ptr_q] <= pend_last_q;
      end
   end

endmodule

// File: tb/tb_bank_stream_ctrl.sv
// Bench for bank_stream_ctrl: behavioural bank, reference memory map,
// scoreboard queues for bank writes and drain beats, and a monitor.
module tb_bank_stream_ctrl;
  localparam int DW = 32;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_rd;
  logic [AW-1:0] cmd_base, cmd_len_m1;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_data_in, bank_data_out;
  logic          bank_we, busy, done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  bank_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_base(cmd_base), .cmd_len_m1(cmd_len_m1),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .bank_addr(bank_addr), .bank_data_in(bank_data_in), .bank_we(bank_we),
    .bank_data_out(bank_data_out), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // behavioural single-port bank, read-first, one-cycle registered read
  logic [DW-1:0] bank_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (bank_mem.exists(bank_addr)) bank_data_out <= bank_mem[bank_addr];
    else bank_data_out <= '0;
    if (bank_we) bank_mem[bank_addr] = bank_data_in;
  end

  // reference model and scoreboard
  logic [DW-1:0]    ref_mem [logic [AW-1:0]];
  logic [DW:0]      exp_q[$];     // {last, data}
  logic [AW+DW-1:0] wexp_q[$];    // {addr, data}
  int  total = 0;
  int  bad = 0;
  int  load_left = 0;
  int  pops = 0;
  int  ready_mode = 0;            // 0: always ready, 1: random, 2: low
  bit  done_exp_cur = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // m_ready driver
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops expectations whenever the DUT presents a transfer
  initial begin
    bit prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;
    bit due_next;
    logic [DW:0] e;
    logic [AW+DW-1:0] w;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        done_exp_cur = 1'b0;
        continue;
      end
      due_next = 1'b0;
      chk("done_pulse", 64'(done), 64'(done_exp_cur));
      chk("we_only_on_hs", 64'(bank_we), 64'(s_valid && s_ready));
      chk("occ_max", 64'(dut.occ_q <= 2'd2), 64'd1);
      if (bank_we) begin
        if (wexp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, none required", bank_addr, bank_data_in);
        end else begin
          w = wexp_q.pop_front();
          chk("wr_addr", 64'(bank_addr), 64'(w[AW+DW-1:DW]));
          chk("wr_data", 64'(bank_data_in), 64'(w[DW-1:0]));
          if (load_left > 0) begin
            load_left--;
            if (load_left == 0) due_next = 1'b1;
          end
        end
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(prev_data));
        chk("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: data %0h last %0b, none required", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_data), 64'(e[DW-1:0]));
          chk("beat_last", 64'(m_last), 64'(e[DW]));
          pops++;
          if (e[DW]) due_next = 1'b1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      done_exp_cur = due_next;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_base = '0; cmd_len_m1 = '0;
    s_valid = 1'b0; s_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); wexp_q.delete(); load_left = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!cmd_ready && n < budget);
    chk(name, 64'(cmd_ready), 64'd1);
  endtask

  task automatic issue_cmd(input bit rd, input logic [AW-1:0] base, input logic [AW-1:0] len);
    wait_idle("cmd_wait_idle", 2000);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rd = rd; cmd_base = base; cmd_len_m1 = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_base = AW'($urandom); cmd_len_m1 = AW'($urandom);
  endtask

  // data_mode 0: 0xA0 + i, otherwise random words
  task automatic run_load(input logic [AW-1:0] base, input int len, input bit data_mode,
                          input bit gaps, output int cyc);
    logic [DW-1:0] words[$];
    logic [AW-1:0] a;
    int i;
    bit hs;
    for (int k = 0; k <= len; k++) begin
      words.push_back(data_mode ? DW'($urandom) : DW'(32'hA0 + k));
      a = base + AW'(k);
      ref_mem[a] = words[k];
      wexp_q.push_back({a, words[k]});
    end
    load_left = len + 1;
    issue_cmd(1'b0, base, AW'(len));
    i = 0; cyc = 0;
    while (i <= len && cyc < 1000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = s_valid ? words[i] : DW'($urandom);
      @(negedge clk); hs = s_valid && s_ready;
      @(posedge clk); #1; cyc++;
      if (hs) i++;
    end
    s_valid = 1'b0;
    chk("load_all_words", 64'(i), 64'(len + 1));
  endtask

  task automatic start_drain(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    for (int k = 0; k <= len; k++) begin
      a = base + AW'(k);
      exp_q.push_back({k == len, ref_mem.exists(a) ? ref_mem[a] : DW'(0)});
    end
    issue_cmd(1'b1, base, AW'(len));
  endtask

  initial begin
    int cyc, lat, run, p0, n;
    do_reset();
    // reset values
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_bank_we", 64'(bank_we), 64'd0);
    chk("rst_bank_addr", 64'(bank_addr), 64'd0);
    chk("rst_bank_data_in", 64'(bank_data_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // load 0xA0..0xA7 at 0x10, then drain with m_ready held high
    ready_mode = 0;
    run_load(21'h10, 7, 1'b0, 1'b0, cyc);
    chk("load_cycles", 64'(cyc), 64'd8);
    wait_idle("load_end", 100);
    start_drain(21'h10, 7);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!m_valid && lat < 20);
    chk("drain_first_latency", 64'(lat), 64'd3);
    run = 1;
    while (run < 20) begin
      @(negedge clk);
      if (!m_valid) break;
      run++;
    end
    chk("drain_burst_len", 64'(run), 64'd8);
    wait_idle("drain_end", 100);

    // load with s_valid gaps, drain under random backpressure
    run_load(21'h300, 19, 1'b1, 1'b1, cyc);
    wait_idle("gap_load_end", 200);
    ready_mode = 1;
    start_drain(21'h300, 19);
    wait_idle("gap_drain_end", 500);

    // 64-word drain with 50% m_ready, plus a command ignored while busy
    ready_mode = 0;
    run_load(21'h1000, 63, 1'b1, 1'b0, cyc);
    wait_idle("big_load_end", 200);
    ready_mode = 1;
    start_drain(21'h1000, 63);
    n = 0;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_base = 21'h1000; cmd_len_m1 = 21'd5;
    while (n < 6) begin
      @(negedge clk);
      chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1; n++;
    end
    cmd_valid = 1'b0;
    wait_idle("big_drain_end", 2000);

    // address wrap at the top of the bank
    run_load(21'h1FFFFE, 3, 1'b1, 1'b1, cyc);
    wait_idle("wrap_load_end", 100);
    start_drain(21'h1FFFFE, 3);
    wait_idle("wrap_drain_end", 200);

    // reset after 3 of 8 drained words, then a fresh drain
    ready_mode = 0;
    run_load(21'h200, 7, 1'b1, 1'b0, cyc);
    wait_idle("rst_load_end", 100);
    start_drain(21'h200, 7);
    p0 = pops - 0;
    p0 = p0 + 3;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (pops < p0 && n < 100);
    chk("rst_pre_pops", 64'(pops >= p0), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete(); wexp_q.delete(); load_left = 0;
    @(negedge clk);
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    ready_mode = 1;
    start_drain(21'h200, 7);
    wait_idle("post_rst_drain_end", 300);

    // single-word load and drains
    run_load(21'h400, 0, 1'b1, 1'b0, cyc);
    wait_idle("single_load_end", 50);
    start_drain(21'h400, 0);
    wait_idle("single_drain_end", 50);
    start_drain(21'h10, 0);
    wait_idle("single_drain2_end", 50);

    repeat (4) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("wexp_q_empty", 64'(wexp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bank_stream_ctrl.md
# bank_stream_ctrl

Stream-side controller that sits directly upstream and downstream of a single-port URAM coefficient bank (`bank3_uram`/`bank4_uram`, 1-cycle registered read). On a load command it writes a valid/ready input stream into consecutive bank addresses. On a drain command it reads consecutive addresses and presents them on a valid/ready output stream with `last`. The output path absorbs the bank's read latency and downstream backpressure without dropping or duplicating words.

## Interface
- `DATA_WIDTH`, 32: coefficient width; must match the bank.
- `ADDR_WIDTH`, 21: bank address width; must match the bank.
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high only in IDLE.
- `cmd_rd` input 1: 0 = load (write bank), 1 = drain (read bank).
- `cmd_base` input ADDR_WIDTH: first bank address.
- `cmd_len_m1` input ADDR_WIDTH: word count minus 1.
- `s_valid`, `s_ready` input/output 1: load-stream handshake.
- `s_data` input DATA_WIDTH: load-stream word.
- `m_valid`, `m_ready` output/input 1: drain-stream handshake.
- `m_data` output DATA_WIDTH: drain-stream word.
- `m_last` output 1: marks the final word of a drain.
- `bank_addr` output ADDR_WIDTH: to bank `addr`.
- `bank_data_in` output DATA_WIDTH: to bank `data_in`.
- `bank_we` output 1: to bank `we`.
- `bank_data_out` input DATA_WIDTH: from bank `data_out`.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse when a command completes.

## Operation
- **States:** IDLE, LOAD, DRAIN.
- **Command accept:** `cmd_valid && cmd_ready` latches base, len_m1 and mode, clears the word counter, and moves to LOAD or DRAIN on the next cycle.
- **Address arithmetic:** `bank_addr = base + cnt`, computed modulo 2^ADDR_WIDTH; addresses wrap past the top of the bank.
- **LOAD:**
  - `s_ready` = 1.
  - `bank_we = s_valid && s_ready`, driven combinationally; `bank_data_in = s_data`.
  - Each handshake increments `cnt`.
  - On the handshake with `cnt == len_m1`: pulse `done` next cycle and return to IDLE; `s_ready` drops the cycle after that handshake.
- **DRAIN:**
  - Read counter `rcnt` and issued flag `all_issued`.
  - Issue a read (`bank_addr = base + rcnt`, `bank_we` = 0) when `!all_issued && (occ + pend - pop) < 2`.
    - `occ` = skid-FIFO occupancy (0..2).
    - `pend` = read issued in the previous cycle.
    - `pop = m_valid && m_ready`.
  - `pend` registers the issue. While `pend` = 1, `bank_data_out` is pushed into a 2-entry FIFO, together with a last bit set when that read was `rcnt == len_m1`.
  - Push and pop may occur in the same cycle; `occ` then stays unchanged.
  - `m_valid = (occ != 0)`. `m_data`/`m_last` come from the FIFO head and stay stable while `m_valid && !m_ready`.
  - Completion: the `m_last` word pops → `done` pulses next cycle and the state returns to IDLE.
- **`bank_we`** is 0 in every state except LOAD during a handshake.
- **`bank_data_out`** is ignored whenever `pend` = 0.
- **Reset mid-operation:** aborts the command, flushes the FIFO, stops further writes, and returns to IDLE. Bank contents are not cleared.

## Timing
- **Reset values:**
  - `cmd_ready` = 1.
  - `s_ready`, `m_valid`, `m_last`, `bank_we`, `busy`, `done` = 0.
  - `m_data`, `bank_addr`, `bank_data_in` = 0.
  - `occ`, `pend`, `cnt`, `rcnt` = 0.
- **Command to first activity:** 1 cycle (first write or first read issue is in the cycle after accept).
- **Load throughput:** 1 word/cycle.
- **Drain:**
  - Read issue to `m_valid`: 2 cycles (bank register plus FIFO register).
  - 1 word/cycle sustained while `m_ready` = 1.
  - At most 2 words are buffered or in flight, so none is lost under arbitrary `m_ready`.
- **`len_m1` = 0:** a single word, with `m_last` on that word.
- **`cmd_valid` during `busy`:** ignored; a command is accepted only in IDLE.

## Test plan
- **Load then drain:** load base=0x10, len_m1=7, data 0xA0..0xA7 with `s_valid` held high → 8 consecutive writes to 0x10..0x17 and `done` 1 cycle after the 8th. Then drain with `m_ready`=1 → 0xA0..0xA7 on 8 consecutive cycles starting 2 cycles after the first issue, `m_last` on 0xA7.
- **Drain under backpressure:** pseudo-random 50% `m_ready` over 64 words → exact in-order sequence, no duplicates, `m_data` stable while stalled, FIFO occupancy never above 2.
- **Load stream gaps:** `s_valid` toggling → `bank_we` only on handshakes and addresses strictly consecutive.
- **Address wrap:** ADDR_WIDTH=4, base=14, len_m1=3 → writes and reads at 14, 15, 0, 1.
- **Reset mid-drain:** `rst` asserted after 3 of 8 words → next cycle `m_valid`=0, IDLE, `cmd_ready`=1. A new drain then returns the correct data from its base.
- **Single word and ignored command:** `len_m1`=0 drain → one beat with `m_last`=1. `cmd_valid` asserted while `busy` → no effect.
